// File: rtl/core_bus_arbiter.sv
// Merges the core's fetch and data req/gnt/rvalid ports onto one memory port.
// Data has fixed priority, with a starvation override for fetch; an owner FIFO routes responses back.
module core_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        protocol_err_o
);

    localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [MAX_OUTSTANDING-1:0] owner_reg;
    logic [MAX_OUTSTANDING-1:0] slot_we;
    logic [PTR_W-1:0]           wr_ptr_reg;
    logic [PTR_W-1:0]           rd_ptr_reg;
    logic [CNT_W-1:0]           count_reg;
    logic [CNT_W-1:0]           count_next;
    logic [STARVE_W-1:0]        starve_cnt_reg;
    logic                       ready_reg;
    logic                       protocol_err_reg;

    logic bus_en;
    logic fifo_full;
    logic fifo_empty;
    logic sel_instr;
    logic push;
    logic pop;
    logic head;

    // Outputs stay quiet during reset and for the first cycle after it.
    assign bus_en     = ~rst & ready_reg;
    assign fifo_full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_reg == '0);

    assign sel_instr = instr_req_i & (~data_req_i | (starve_cnt_reg == STARVE_W'(STARVE_LIMIT)));

    assign mem_req_o   = bus_en & (instr_req_i | data_req_i) & ~fifo_full;
    assign push        = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = push & sel_instr;
    assign data_gnt_o  = push & ~sel_instr;

    assign mem_we_o    = sel_instr ? 1'b0 : data_we_i;
    assign mem_be_o    = sel_instr ? 4'hF : data_be_i;
    assign mem_addr_o  = sel_instr ? instr_addr_i : data_addr_i;
    assign mem_wdata_o = sel_instr ? 32'h0 : data_wdata_i;

    assign head           = owner_reg[rd_ptr_reg];
    assign pop            = bus_en & mem_rvalid_i & ~fifo_empty;
    assign instr_rvalid_o = pop & head;
    assign data_rvalid_o  = pop & ~head;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;
    assign protocol_err_o = protocol_err_reg;

    generate
        for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_slot
            assign slot_we[gi] = push & (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (slot_we[i]) begin
                owner_reg[i] <= sel_instr;
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            starve_cnt_reg   <= '0;
            ready_reg        <= 1'b0;
            protocol_err_reg <= 1'b0;
        end else begin
            ready_reg <= 1'b1;
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            // A response with nothing outstanding is dropped but remembered.
            if (mem_rvalid_i && fifo_empty) begin
                protocol_err_reg <= 1'b1;
            end
            // Only cycles actually lost to a data grant count towards starvation.
            if (!instr_req_i || instr_gnt_o) begin
                starve_cnt_reg <= '0;
            end else if (data_gnt_o && (starve_cnt_reg != STARVE_W'(STARVE_LIMIT))) begin
                starve_cnt_reg <= starve_cnt_reg + STARVE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed and randomized bench for core_bus_arbiter, checked against a queue-based reference model.
module tb_core_bus_arbiter;

    localparam int MAXO  = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req, instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_gnt, data_rvalid, data_we, data_err;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_gnt, mem_rvalid, mem_we, mem_err, protocol_err;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_q[$];
    int m_starve;
    bit m_perr;
    bit m_ready;
    bit e_req, e_igrant, e_dgrant, e_irv, e_drv;

    always #5 clk = ~clk;

    core_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
        .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
        .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_err_o(data_err),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .protocol_err_o(protocol_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against what the model says for the current inputs.
    task automatic model_check();
        bit en, full, sel;
        en       = !rst && m_ready;
        full     = (m_q.size() == MAXO);
        sel      = instr_req && (!data_req || m_starve == LIMIT);
        e_req    = en && (instr_req || data_req) && !full;
        e_igrant = e_req && mem_gnt && sel;
        e_dgrant = e_req && mem_gnt && !sel;
        e_irv    = 1'b0;
        e_drv    = 1'b0;
        if (en && mem_rvalid && m_q.size() > 0) begin
            e_irv = m_q[0];
            e_drv = !m_q[0];
        end
        chk("mem_req", {31'b0, mem_req}, {31'b0, e_req});
        chk("instr_gnt", {31'b0, instr_gnt}, {31'b0, e_igrant});
        chk("data_gnt", {31'b0, data_gnt}, {31'b0, e_dgrant});
        chk("instr_rvalid", {31'b0, instr_rvalid}, {31'b0, e_irv});
        chk("data_rvalid", {31'b0, data_rvalid}, {31'b0, e_drv});
        chk("protocol_err", {31'b0, protocol_err}, {31'b0, m_perr});
        if (mem_rvalid) begin
            chk("instr_rdata", instr_rdata, mem_rdata);
            chk("data_rdata", data_rdata, mem_rdata);
            chk("instr_err", {31'b0, instr_err}, {31'b0, mem_err});
            chk("data_err", {31'b0, data_err}, {31'b0, mem_err});
        end
        if (instr_req || data_req) begin
            chk("mem_addr", mem_addr, sel ? instr_addr : data_addr);
            chk("mem_we", {31'b0, mem_we}, sel ? 32'h0 : {31'b0, data_we});
            chk("mem_be", {28'b0, mem_be}, sel ? 32'hF : {28'b0, data_be});
            chk("mem_wdata", mem_wdata, sel ? 32'h0 : data_wdata);
        end
    endtask

    task automatic model_update();
        if (e_igrant) $display("grant instr addr=%h", mem_addr);
        if (e_dgrant) $display("grant data  addr=%h we=%0d be=%h", mem_addr, mem_we, mem_be);
        if (e_irv || e_drv) $display("resp  %s rdata=%h err=%0d", e_irv ? "instr" : "data ", mem_rdata, mem_err);
        if (rst) begin
            m_q.delete();
            m_starve = 0;
            m_perr   = 1'b0;
            m_ready  = 1'b0;
        end else begin
            m_ready = 1'b1;
            if (mem_rvalid && m_q.size() == 0) m_perr = 1'b1;
            if (e_irv || e_drv) void'(m_q.pop_front());
            if (e_igrant) m_q.push_back(1'b1);
            if (e_dgrant) m_q.push_back(1'b0);
            if (!instr_req || e_igrant) m_starve = 0;
            else if (e_dgrant && m_starve < LIMIT) m_starve++;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req = 0; instr_addr = 0;
        data_req = 0; data_we = 0; data_be = 0; data_addr = 0; data_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        sample();
        advance();
        rst = 0;
        sample();
        advance();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        m_starve = 0; m_perr = 0; m_ready = 0;
        @(posedge clk); #1;

        // Reset state, with requests applied to show outputs stay low
        instr_req = 1; data_req = 1; mem_gnt = 1;
        sample();
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_perr", {31'b0, protocol_err}, 32'h0);
        advance();
        rst = 0;
        sample();
        chk("post_rst_gnt", {30'b0, instr_gnt, data_gnt}, 32'h0);
        chk("post_rst_req", {31'b0, mem_req}, 32'h0);
        advance();
        do_reset();

        // Single fetch
        instr_req = 1; instr_addr = 32'h0000_0100; mem_gnt = 1;
        sample();
        chk("fetch_gnt", {31'b0, instr_gnt}, 32'h1);
        chk("fetch_addr", mem_addr, 32'h0000_0100);
        advance();
        instr_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
        sample();
        chk("fetch_rvalid", {31'b0, instr_rvalid}, 32'h1);
        chk("fetch_rdata", instr_rdata, 32'h0000_0013);
        chk("fetch_no_drv", {31'b0, data_rvalid}, 32'h0);
        advance();
        idle_inputs();

        // Priority and starvation override
        instr_req = 1; instr_addr = 32'h0000_0200;
        data_req = 1; data_addr = 32'h1000_0000; data_be = 4'hF; mem_gnt = 1;
        for (int c = 0; c < 6; c++) begin
            mem_rvalid = (c > 0);
            mem_rdata = 32'(c);
            sample();
            chk($sformatf("prio_c%0d_igrant", c), {31'b0, instr_gnt}, (c == 4) ? 32'h1 : 32'h0);
            chk($sformatf("prio_c%0d_dgrant", c), {31'b0, data_gnt}, (c == 4) ? 32'h0 : 32'h1);
            advance();
        end
        idle_inputs();
        mem_rvalid = 1;
        sample();
        advance();
        idle_inputs();

        // Full FIFO blocks a grant even when a response pops in the same cycle
        data_req = 1; data_addr = 32'h3000_0000; data_be = 4'h1; mem_gnt = 1;
        for (int c = 0; c < 4; c++) begin
            mem_rvalid = (c == 2);
            sample();
            chk($sformatf("full_c%0d_req", c), {31'b0, mem_req}, (c == 2) ? 32'h0 : 32'h1);
            chk($sformatf("full_c%0d_dgrant", c), {31'b0, data_gnt}, (c == 2) ? 32'h0 : 32'h1);
            advance();
        end
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            mem_rvalid = 1;
            sample();
            chk("full_drain", {31'b0, data_rvalid}, 32'h1);
            advance();
        end
        idle_inputs();

        // Interleaved routing with error on the fetch response
        data_req = 1; data_we = 1; data_be = 4'b0011; data_addr = 32'h2000_0000; data_wdata = 32'hCAFE_F00D;
        instr_req = 1; instr_addr = 32'h0000_0400; mem_gnt = 1;
        sample();
        chk("il_dgrant", {31'b0, data_gnt}, 32'h1);
        chk("il_dbe", {28'b0, mem_be}, 32'h3);
        advance();
        data_req = 0;
        sample();
        chk("il_igrant", {31'b0, instr_gnt}, 32'h1);
        chk("il_ibe", {28'b0, mem_be}, 32'hF);
        chk("il_iwe", {31'b0, mem_we}, 32'h0);
        advance();
        instr_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1111_1111; mem_err = 0;
        sample();
        chk("il_resp1", {30'b0, data_rvalid, instr_rvalid}, 32'h2);
        advance();
        mem_rdata = 32'h2222_2222; mem_err = 1;
        sample();
        chk("il_resp2", {30'b0, data_rvalid, instr_rvalid}, 32'h1);
        chk("il_ierr", {31'b0, instr_err}, 32'h1);
        advance();
        idle_inputs();

        // Stray response
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        sample();
        chk("stray_rv", {30'b0, data_rvalid, instr_rvalid}, 32'h0);
        chk("stray_perr_now", {31'b0, protocol_err}, 32'h0);
        advance();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("stray_perr_hold", {31'b0, protocol_err}, 32'h1);
            advance();
        end

        // Reset mid-flight: late response is dropped and flagged
        do_reset();
        instr_req = 1; instr_addr = 32'h0000_0800; mem_gnt = 1;
        sample();
        chk("mid_grant", {31'b0, instr_gnt}, 32'h1);
        advance();
        idle_inputs();
        rst = 1;
        sample();
        advance();
        rst = 0;
        sample();
        advance();
        mem_rvalid = 1; mem_rdata = 32'h5555_5555;
        sample();
        chk("mid_no_rv", {30'b0, data_rvalid, instr_rvalid}, 32'h0);
        advance();
        idle_inputs();
        sample();
        chk("mid_perr", {31'b0, protocol_err}, 32'h1);
        advance();

        // Randomized traffic; masters hold their request until granted
        do_reset();
        e_igrant = 0; e_dgrant = 0;
        for (int c = 0; c < 400; c++) begin
            if (!instr_req || e_igrant) begin
                instr_req  = ($urandom_range(0, 2) != 0);
                instr_addr = $urandom;
            end
            if (!data_req || e_dgrant) begin
                data_req   = ($urandom_range(0, 2) != 0);
                data_addr  = $urandom;
                data_we    = $urandom_range(0, 1);
                data_be    = 4'($urandom);
                data_wdata = $urandom;
            end
            mem_gnt    = ($urandom_range(0, 3) != 0);
            mem_rvalid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata  = $urandom;
            mem_err    = ($urandom_range(0, 7) == 0);
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Sits directly downstream of tinyriscv_core.
- Merges the core's instruction-fetch port and data-access port (both req/gnt/rvalid style) onto a single memory-side port of the same protocol.
- Arbitrates requests; fixed priority favours data, with an anti-starvation override for fetch.
- Records the owner of every granted transaction in a small in-order FIFO and routes each response back to that owner.

Parameters:
MAX_OUTSTANDING, 2, owner-FIFO depth = max granted-but-unanswered transactions (power of two, >=1)
STARVE_LIMIT, 4, consecutive cycles instr may be refused while requesting before it takes priority

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr_req_i  in  1  fetch request
instr_gnt_o  out  1  fetch request accepted
instr_rvalid_o  out  1  fetch response valid
instr_addr_i  in  32  fetch address
instr_rdata_o  out  32  fetch read data
instr_err_o  out  1  fetch bus error, valid with instr_rvalid_o
data_req_i  in  1  data request
data_gnt_o  out  1  data request accepted
data_rvalid_o  out  1  data response valid
data_we_i  in  1  write enable
data_be_i  in  4  byte enables
data_addr_i  in  32  data address
data_wdata_i  in  32  write data
data_rdata_o  out  32  read data
data_err_o  out  1  data bus error, valid with data_rvalid_o
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory accepted request
mem_rvalid_i  in  1  memory response valid
mem_we_o  out  1  write enable (0 for fetch)
mem_be_o  out  4  byte enables (4'hF for fetch)
mem_addr_o  out  32  address
mem_wdata_o  out  32  write data (0 for fetch)
mem_rdata_i  in  32  read data
mem_err_i  in  1  bus error
protocol_err_o  out  1  sticky: response arrived with no outstanding transaction

Behaviour:
- Clocking and reset: single clock domain. rst is sampled on the clk rising edge only.
- Reset state: owner FIFO empty, starve counter 0, protocol_err_o 0. All gnt, rvalid and req outputs are 0 while rst is high and in the first cycle after it.
- Arbitration (combinational, same cycle):
  - sel_instr = instr_req_i & (~data_req_i | starve_cnt == STARVE_LIMIT).
  - Otherwise data wins when data_req_i.
  - Request fields are muxed from the selected master.
- Request gating:
  - mem_req_o = (instr_req_i | data_req_i) & ~fifo_full.
  - Winner's gnt_o = mem_req_o & mem_gnt_i. Loser's gnt_o = 0.
- No combinational path from any rvalid to any req or gnt. A full FIFO blocks new requests even when mem_rvalid_i pops in the same cycle.
- Owner FIFO:
  - Push the owner bit (1 = instr) on mem_req_o & mem_gnt_i.
  - Pop on mem_rvalid_i.
  - Simultaneous push and pop (when not full) keeps the count unchanged.
  - Pointers wrap modulo MAX_OUTSTANDING. Count width is clog2(MAX_OUTSTANDING)+1.
- Response routing:
  - Combinational from the FIFO head.
  - instr_rvalid_o = mem_rvalid_i & ~empty & head.
  - data_rvalid_o = mem_rvalid_i & ~empty & ~head.
  - rdata and err are forwarded to both masters unconditionally; only rvalid qualifies them.
  - Responses are in grant order. The memory must return responses in order.
- Stray response: mem_rvalid_i while the FIFO is empty is dropped (no rvalid to either master) and sets protocol_err_o, which holds until rst.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) in each cycle where instr_req_i=1 and instr_gnt_o=0 because data won arbitration.
  - Clears on any instr grant, or when instr_req_i=0.
  - Cycles stalled by mem_gnt_i=0 or a full FIFO do not count.
- Request stability: a master holds its req and fields until granted. The arbiter may switch its selection between cycles while no grant has occurred.
- Reset mid-transaction: the FIFO is discarded. Late responses after reset set protocol_err_o.

Test Plan:
- Single fetch: instr_req_i=1, addr 0x0000_0100, mem_gnt_i=1; mem_rvalid_i next cycle with rdata 0x0000_0013 -> instr_gnt_o=1 in cycle 0; instr_rvalid_o=1 with rdata 0x13 in cycle 1; data_rvalid_o=0.
- Priority and starvation: data_req_i and instr_req_i held high, mem_gnt_i=1 every cycle, responses one cycle later -> data granted for cycles 0-3; instr granted in cycle 4 (STARVE_LIMIT=4); counter resets; data granted again in cycle 5.
- Full FIFO: two grants with no rvalid -> mem_req_o=0 and both gnt=0 in cycle 2. In that cycle mem_rvalid_i=1 -> still no grant that cycle; grant resumes in cycle 3.
- Interleaved routing: grant data write (addr 0x2000_0000, be 4'b0011), then instr fetch; return two responses, the second with mem_err_i=1 -> data_rvalid_o first, then instr_rvalid_o with instr_err_o=1; mem_be_o=4'hF and mem_we_o=0 during the fetch grant.
- Stray response: mem_rvalid_i=1 with FIFO empty -> no rvalid to either master; protocol_err_o rises next cycle and stays 1 until rst.
- Reset mid-flight: one outstanding, assert rst for 1 cycle, then mem_rvalid_i=1 -> no rvalid to either master; protocol_err_o=1.
